// File: rtl/elastic_pipe_pkg.sv
// Shared constants, operation encoding and pointer helper for the elastic pipe.
// Optional level output is enabled by defining ELASTIC_PIPE_LEVEL_EN.
package elastic_pipe_pkg;

  localparam int DEF_L     = 8;
  localparam int DEF_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Depth need not be a power of two, so wrap explicitly instead of overflowing.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Valid/ready handshake bundle for both sides of the elastic pipe.
// The pipe itself uses the slave modport; the driving environment uses master.
interface elastic_pipe_if #(
  parameter int L = 8
);
  logic         valid_f;
  logic         ready_f;
  logic [L-1:0] data_f;
  logic         valid_b;
  logic         ready_b;
  logic [L-1:0] data_b;

  modport slave (
    input  valid_f, data_f, ready_b,
    output ready_f, valid_b, data_b
  );

  modport master (
    output valid_f, data_f, ready_b,
    input  ready_f, valid_b, data_b
  );
endinterface

// File: rtl/elastic_pipe_mem.sv
// DEPTH x L storage with a single write port and a registered read output.
// The read register forwards the write data when both target the same entry.
module elastic_pipe_mem #(
  parameter  int L     = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [L-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [L-1:0]     rdata
);

  logic [L-1:0] mem_q [DEPTH];
  logic [L-1:0] rdata_d;
  logic [L-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Forwarding gives the one-cycle latency when the head entry is written this cycle.
  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/elastic_pipe.sv
// Elastic valid/ready buffer of DEPTH entries with fully registered outputs.
// Define ELASTIC_PIPE_LEVEL_EN to expose the occupancy count on port level.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int L     = DEF_L,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  elastic_pipe_if.slave                bus
`ifdef ELASTIC_PIPE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_d, count_q;
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             ready_d, ready_q;
  logic             valid_d, valid_q;
  logic             push;
  logic             pop;
  logic             we;
  logic [L-1:0]     rdata;
  op_e              op;

  assign push = bus.valid_f && ready_q;
  assign pop  = valid_q && bus.ready_b;
  assign op   = op_e'({push, pop});

  // Flush overrides any transfer; a flushed push must not touch storage either.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we       = 1'b0;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          we       = 1'b1;
          count_d  = count_q + CNT_W'(1);
          wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
        end
        OP_POP: begin
          count_d  = count_q - CNT_W'(1);
          rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
        end
        OP_BOTH: begin
          we       = 1'b1;
          wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
          rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    ready_d = (count_d != CNT_W'(DEPTH));
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  // Reading at the next read pointer keeps data_b aligned with the new head.
  elastic_pipe_mem #(
    .L     (L),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (bus.data_f),
    .raddr (rd_ptr_d),
    .rdata (rdata)
  );

  assign bus.ready_f = ready_q;
  assign bus.valid_b = valid_q;
  assign bus.data_b  = rdata;

`ifdef ELASTIC_PIPE_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed self-checking bench for elastic_pipe at DEPTH 2, 4 and 3.
// Level checks are included when ELASTIC_PIPE_LEVEL_EN is defined.
module tb_elastic_pipe;

  logic clk;
  logic rst;
  logic flush2, flush4, flush3;
  int   num_checks;
  int   num_fails;

  elastic_pipe_if #(.L(8)) bus2 ();
  elastic_pipe_if #(.L(8)) bus4 ();
  elastic_pipe_if #(.L(8)) bus3 ();

`ifdef ELASTIC_PIPE_LEVEL_EN
  logic [1:0] level2;
  logic [2:0] level4;
  logic [1:0] level3;
`endif

  elastic_pipe #(.L(8), .DEPTH(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush2),
    .bus   (bus2)
`ifdef ELASTIC_PIPE_LEVEL_EN
    ,
    .level (level2)
`endif
  );

  elastic_pipe #(.L(8), .DEPTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush4),
    .bus   (bus4)
`ifdef ELASTIC_PIPE_LEVEL_EN
    ,
    .level (level4)
`endif
  );

  elastic_pipe #(.L(8), .DEPTH(3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush3),
    .bus   (bus3)
`ifdef ELASTIC_PIPE_LEVEL_EN
    ,
    .level (level3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    num_checks   = 0;
    num_fails    = 0;
    rst          = 1'b0;
    flush2       = 1'b0;
    flush4       = 1'b0;
    flush3       = 1'b0;
    bus2.valid_f = 1'b0; bus2.data_f = 8'h00; bus2.ready_b = 1'b0;
    bus4.valid_f = 1'b0; bus4.data_f = 8'h00; bus4.ready_b = 1'b0;
    bus3.valid_f = 1'b0; bus3.data_f = 8'h00; bus3.ready_b = 1'b0;

    #12;
    checkOutput("rst_ready2", 32'(bus2.ready_f), 32'd1);
    checkOutput("rst_valid2", 32'(bus2.valid_b), 32'd0);
    checkOutput("rst_data2",  32'(bus2.data_b),  32'h00);
    checkOutput("rst_ready4", 32'(bus4.ready_f), 32'd1);
    checkOutput("rst_valid4", 32'(bus4.valid_b), 32'd0);
    checkOutput("rst_ready3", 32'(bus3.ready_f), 32'd1);
    checkOutput("rst_valid3", 32'(bus3.valid_b), 32'd0);
`ifdef ELASTIC_PIPE_LEVEL_EN
    checkOutput("rst_level4", 32'(level4), 32'd0);
`endif

    // Single word through DEPTH=2, pushed on the first edge after reset release.
    rst          = 1'b1;
    bus2.valid_f = 1'b1;
    bus2.data_f  = 8'hA5;
    bus2.ready_b = 1'b1;
    applyStimulus(1);
    bus2.valid_f = 1'b0;
    checkOutput("a5_valid", 32'(bus2.valid_b), 32'd1);
    checkOutput("a5_data",  32'(bus2.data_b),  32'hA5);
    checkOutput("a5_ready", 32'(bus2.ready_f), 32'd1);
    applyStimulus(1);
    checkOutput("a5_popped", 32'(bus2.valid_b), 32'd0);

    // Fill DEPTH=2, then push and pop on the same edge while full.
    bus2.ready_b = 1'b0;
    bus2.valid_f = 1'b1;
    bus2.data_f  = 8'h11;
    applyStimulus(1);
    bus2.data_f  = 8'h22;
    applyStimulus(1);
    checkOutput("full_ready", 32'(bus2.ready_f), 32'd0);
    checkOutput("full_valid", 32'(bus2.valid_b), 32'd1);
    checkOutput("full_data",  32'(bus2.data_b),  32'h11);
`ifdef ELASTIC_PIPE_LEVEL_EN
    checkOutput("full_level", 32'(level2), 32'd2);
`endif
    bus2.data_f  = 8'h33;
    bus2.ready_b = 1'b1;
    applyStimulus(1);
    bus2.valid_f = 1'b0;
    checkOutput("fullpp_ready", 32'(bus2.ready_f), 32'd1);
    checkOutput("fullpp_valid", 32'(bus2.valid_b), 32'd1);
    checkOutput("fullpp_data",  32'(bus2.data_b),  32'h22);
`ifdef ELASTIC_PIPE_LEVEL_EN
    checkOutput("fullpp_level", 32'(level2), 32'd1);
`endif
    applyStimulus(1);
    checkOutput("fullpp_no33", 32'(bus2.valid_b), 32'd0);

    // DEPTH=4 backpressure: fifth word must be refused, head held stable.
    bus4.ready_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus4.valid_f = 1'b1;
      bus4.data_f  = 8'(i);
      applyStimulus(1);
      checkOutput($sformatf("bp_ready_%0d", i), 32'(bus4.ready_f), (i < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("bp_head_%0d", i), 32'(bus4.data_b), 32'h01);
    end
    bus4.valid_f = 1'b0;
    bus4.ready_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("drain_valid_%0d", i), 32'(bus4.valid_b), 32'd1);
      checkOutput($sformatf("drain_data_%0d", i),  32'(bus4.data_b),  32'(i));
      applyStimulus(1);
    end
    checkOutput("drain_empty", 32'(bus4.valid_b), 32'd0);

    // DEPTH=3 streaming: one word per cycle across several pointer wraps.
    bus3.ready_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus3.valid_f = 1'b1;
      bus3.data_f  = 8'(i);
      applyStimulus(1);
      checkOutput($sformatf("stream_valid_%0d", i), 32'(bus3.valid_b), 32'd1);
      checkOutput($sformatf("stream_data_%0d", i),  32'(bus3.data_b),  32'(i));
      checkOutput($sformatf("stream_ready_%0d", i), 32'(bus3.ready_f), 32'd1);
    end
    bus3.valid_f = 1'b0;
    applyStimulus(1);
    checkOutput("stream_empty", 32'(bus3.valid_b), 32'd0);

    // Flush with three entries and a concurrent push on DEPTH=4.
    bus4.ready_b = 1'b0;
    bus4.valid_f = 1'b1;
    bus4.data_f  = 8'hA1;
    applyStimulus(1);
    bus4.data_f  = 8'hA2;
    applyStimulus(1);
    bus4.data_f  = 8'hA3;
    applyStimulus(1);
    flush4       = 1'b1;
    bus4.data_f  = 8'hEE;
    applyStimulus(1);
    flush4       = 1'b0;
    bus4.valid_f = 1'b0;
    checkOutput("flush_valid", 32'(bus4.valid_b), 32'd0);
    checkOutput("flush_ready", 32'(bus4.ready_f), 32'd1);
`ifdef ELASTIC_PIPE_LEVEL_EN
    checkOutput("flush_level", 32'(level4), 32'd0);
`endif
    applyStimulus(1);
    checkOutput("flush_no_ee", 32'(bus4.valid_b), 32'd0);
    bus4.valid_f = 1'b1;
    bus4.data_f  = 8'h5C;
    applyStimulus(1);
    bus4.valid_f = 1'b0;
    checkOutput("post_flush_valid", 32'(bus4.valid_b), 32'd1);
    checkOutput("post_flush_data",  32'(bus4.data_b),  32'h5C);
    bus4.ready_b = 1'b1;
    applyStimulus(1);
    checkOutput("post_flush_pop", 32'(bus4.valid_b), 32'd0);

    // Asynchronous reset with two words buffered on DEPTH=3.
    bus3.ready_b = 1'b0;
    bus3.valid_f = 1'b1;
    bus3.data_f  = 8'h71;
    applyStimulus(1);
    bus3.data_f  = 8'h72;
    applyStimulus(1);
    checkOutput("pre_rst_data", 32'(bus3.data_b), 32'h71);
    bus3.data_f  = 8'h73;
    bus3.ready_b = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(bus3.valid_b), 32'd0);
    checkOutput("arst_data",  32'(bus3.data_b),  32'h00);
    checkOutput("arst_ready", 32'(bus3.ready_f), 32'd1);
    bus3.valid_f = 1'b0;
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("arst_no_stale1", 32'(bus3.valid_b), 32'd0);
    applyStimulus(1);
    checkOutput("arst_no_stale2", 32'(bus3.valid_b), 32'd0);
    bus3.valid_f = 1'b1;
    bus3.data_f  = 8'h7A;
    applyStimulus(1);
    bus3.valid_f = 1'b0;
    checkOutput("arst_push_data",  32'(bus3.data_b),  32'h7A);
    checkOutput("arst_push_valid", 32'(bus3.valid_b), 32'd1);
    applyStimulus(1);
    checkOutput("arst_push_pop", 32'(bus3.valid_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter L, default 8, payload width in bits (L >= 1).
REQ-002 SHALL have parameter DEPTH, default 2, buffer entries (DEPTH >= 2; power of two not required).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port valid_f  input  1  upstream data valid.
REQ-007 SHALL have port ready_f  output  1  block can accept; registered.
REQ-008 SHALL have port data_f  input  L  upstream payload.
REQ-009 SHALL have port valid_b  output  1  downstream data valid; registered.
REQ-010 SHALL have port ready_b  input  1  downstream can accept.
REQ-011 SHALL have port data_b  output  L  downstream payload; registered.

Function
REQ-012 SHALL treat a push as valid_f && ready_f, and a pop as valid_b && ready_b, both sampled at the rising edge.
REQ-013 SHALL hold an occupancy count (0..DEPTH) of width $clog2(DEPTH+1); push only +1, pop only -1, both: unchanged.
REQ-014 SHALL drive ready_f = (count != DEPTH), valid_b = (count != 0), data_b = entry at read pointer, all from flops only; no combinational path from ready_b or valid_f to any output.
REQ-015 SHALL give one-cycle latency: data pushed into an empty buffer at edge N appears on data_b with valid_b=1 after edge N.
REQ-016 SHALL preserve order (FIFO) and hold data_b/valid_b stable while valid_b=1 and ready_b=0.
REQ-017 SHALL, when full, ignore valid_f (ready_f=0) and accept a simultaneous pop; ready_f rises after that edge.
REQ-018 SHALL, when count = DEPTH-1, accept a push with no pop and deassert ready_f after that edge.
REQ-019 SHALL, at steady state (push and pop every cycle), sustain one transfer per cycle with count unchanged.
REQ-020 SHALL advance read/write pointers modulo DEPTH, wrapping DEPTH-1 -> 0.
REQ-021 SHALL, on flush=1, set count and both pointers to 0 at the next edge; a push or pop in the same cycle is discarded; flush has priority over all other updates.
REQ-022 SHALL not modify storage contents on a cycle without a push (no spurious writes).

Reset
REQ-023 SHALL, with rst=0, immediately force count=0, pointers=0, ready_f=1, valid_b=0, data_b=0.
REQ-024 SHALL discard all buffered data on reset mid-operation; storage array itself need not be reset.
REQ-025 SHALL accept a push on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro ELASTIC_PIPE_LEVEL_EN defined, add output port level (width $clog2(DEPTH+1)) equal to the registered count, reset 0, cleared by flush.
REQ-027 SHALL, without ELASTIC_PIPE_LEVEL_EN, omit port level entirely with otherwise identical behaviour.

Structure
REQ-028 SHALL place default L/DEPTH constants and a pointer-increment-with-wrap function in shared package elastic_pipe_pkg.
REQ-029 SHALL implement storage as sub-module elastic_pipe_mem (DEPTH x L, one write port, one registered read output); control stays in elastic_pipe.

Verification
REQ-030 SHALL cover: L=8, DEPTH=2, push 0xA5 into empty, ready_b=1 -> valid_b=1, data_b=0xA5 one cycle later, popped next edge.
REQ-031 SHALL cover: DEPTH=4, ready_b=0, push 0x01..0x05 -> ready_f=0 after 4th push, 0x05 not accepted, then ready_b=1 -> 0x01..0x04 out in order.
REQ-032 SHALL cover: DEPTH=3, continuous push/pop of 0x00..0x0F with ready_b=1 -> one word per cycle, order intact across pointer wraps.
REQ-033 SHALL cover: count=3, flush=1 with valid_f=1 -> next cycle valid_b=0, ready_f=1, level=0 (if enabled), pushed word absent.
REQ-034 SHALL cover: rst pulsed low mid-transfer with count=2 -> valid_b=0, data_b=0, ready_f=1 immediately, no stale word emitted afterwards.
REQ-035 SHALL cover: full buffer, push and pop same edge -> pop accepted, push ignored, count=DEPTH-1, ready_f=1 next cycle.
